multicycle_ctrl: RTL and testbench

Multi-cycle control sequencer for the RV32 core. Replaces the single-cycle opcode decoder with a Moore FSM that steps the shared datapath (one ALU, one register-file write port, one PC register) through fetch, decode, execute, memory and write-back phases. It handshakes with instruction and data memories and stops the core on `ebreak`, an illegal opcode or a memory timeout.

---
 rtl/multicycle_ctrl.sv | 175 +++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_ctrl.sv
// Multi-cycle RV32 control sequencer: a Moore FSM that walks the shared datapath
// through fetch, decode, execute, memory and write-back, halting on ebreak, illegal op or timeout.
module multicycle_ctrl #(
  parameter int MAX_WAIT = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] op,
  input  logic       imem_ack,
  input  logic       dmem_ack,
  output logic       imem_req,
  output logic       dmem_req,
  output logic       dmem_we,
  output logic       ir_we,
  output logic       pc_we,
  output logic       reg_write,
  output logic       mem_to_reg,
  output logic [1:0] imm_src,
  output logic       alu_src,
  output logic [1:0] wd_src,
  output logic [1:0] pc_src,
  output logic       halt,
  output logic       err,
  output logic [2:0] state
);

  // Handshake: a request stays high in FETCH/MEM until the matching ack is
  // sampled on a rising edge; the request drops the cycle after that edge.
  localparam int CW = $clog2(MAX_WAIT + 1);
  localparam logic [CW-1:0] WAIT_MAX = CW'(MAX_WAIT);

  localparam int C_LUI    = 0;
  localparam int C_AUIPC  = 1;
  localparam int C_JAL    = 2;
  localparam int C_JALR   = 3;
  localparam int C_OPIMM  = 4;
  localparam int C_OP     = 5;
  localparam int C_LOAD   = 6;
  localparam int C_STORE  = 7;
  localparam int C_EBREAK = 8;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALT   = 3'd6
  } state_t;

  state_t        st;
  logic [8:0]    cls;
  logic [8:0]    dec;
  logic [CW-1:0] wait_cnt;
  logic          err_q;

  // All-zero result marks an illegal opcode.
  always_comb begin
    dec = '0;
    case (op)
      7'b0110111: dec[C_LUI]    = 1'b1;
      7'b0010111: dec[C_AUIPC]  = 1'b1;
      7'b1101111: dec[C_JAL]    = 1'b1;
      7'b1100111: dec[C_JALR]   = 1'b1;
      7'b0010011: dec[C_OPIMM]  = 1'b1;
      7'b0110011: dec[C_OP]     = 1'b1;
      7'b0000011: dec[C_LOAD]   = 1'b1;
      7'b0100011: dec[C_STORE]  = 1'b1;
      7'b1110011: dec[C_EBREAK] = 1'b1;
      default:    dec = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st       <= S_IDLE;
      cls      <= '0;
      wait_cnt <= '0;
      err_q    <= 1'b0;
    end else begin
      case (st)
        S_IDLE: begin
          st       <= S_FETCH;
          wait_cnt <= '0;
        end
        S_FETCH, S_MEM: begin
          // An ack in the expiry cycle still completes the access.
          if ((st == S_FETCH) ? imem_ack : dmem_ack) begin
            st       <= (st == S_FETCH) ? S_DECODE : S_WB;
            wait_cnt <= '0;
          end else if (wait_cnt == WAIT_MAX) begin
            st    <= S_HALT;
            err_q <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + CW'(1);
          end
        end
        S_DECODE: begin
          cls      <= dec;
          wait_cnt <= '0;
          if (dec == '0) begin
            st    <= S_HALT;
            err_q <= 1'b1;
          end else if (dec[C_EBREAK]) begin
            st    <= S_HALT;
            err_q <= 1'b0;
          end else begin
            st <= S_EXEC;
          end
        end
        S_EXEC: begin
          st       <= (cls[C_LOAD] || cls[C_STORE]) ? S_MEM : S_WB;
          wait_cnt <= '0;
        end
        S_WB: begin
          st       <= S_FETCH;
          wait_cnt <= '0;
        end
        S_HALT:  st <= S_HALT;
        default: st <= S_IDLE;
      endcase
    end
  end

  // IR is written every FETCH cycle; the copy taken on the ack edge is the one kept.
  always_comb begin
    imem_req   = 1'b0;
    dmem_req   = 1'b0;
    dmem_we    = 1'b0;
    ir_we      = 1'b0;
    pc_we      = 1'b0;
    reg_write  = 1'b0;
    mem_to_reg = 1'b0;
    imm_src    = 2'b00;
    alu_src    = 1'b0;
    wd_src     = 2'b00;
    pc_src     = 2'b00;
    halt       = 1'b0;
    err        = 1'b0;
    state      = st;
    if (st == S_EXEC || st == S_MEM || st == S_WB) begin
      if (cls[C_LUI] || cls[C_AUIPC]) imm_src = 2'b01;
      if (cls[C_JAL])                 imm_src = 2'b10;
      if (cls[C_STORE])               imm_src = 2'b11;
      alu_src = cls[C_JALR] | cls[C_OPIMM] | cls[C_LOAD] | cls[C_STORE];
    end
    case (st)
      S_FETCH: begin
        imem_req = 1'b1;
        ir_we    = 1'b1;
      end
      S_MEM: begin
        dmem_req = 1'b1;
        dmem_we  = cls[C_STORE];
      end
      S_WB: begin
        pc_we      = 1'b1;
        reg_write  = ~cls[C_STORE];
        mem_to_reg = cls[C_LOAD];
        if (cls[C_LUI])                wd_src = 2'b10;
        if (cls[C_AUIPC])              wd_src = 2'b11;
        if (cls[C_JAL] || cls[C_JALR]) wd_src = 2'b01;
        if (cls[C_JAL])                pc_src = 2'b01;
        if (cls[C_JALR])               pc_src = 2'b10;
      end
      S_HALT: begin
        halt = 1'b1;
        err  = err_q;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Randomized bench for multicycle_ctrl: a per-opcode table plus wait-count arithmetic
// predicts the full per-cycle output trace of each instruction.
module tb_multicycle_ctrl;

  localparam int MW = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [6:0] op = '0;
  logic       imem_ack = 1'b0;
  logic       dmem_ack = 1'b0;
  logic       imem_req, dmem_req, dmem_we, ir_we, pc_we, reg_write, mem_to_reg;
  logic [1:0] imm_src, wd_src, pc_src;
  logic       alu_src, halt, err;
  logic [2:0] state;

  multicycle_ctrl #(.MAX_WAIT(MW)) dut (
    .clk(clk), .rst(rst), .op(op), .imem_ack(imem_ack), .dmem_ack(dmem_ack),
    .imem_req(imem_req), .dmem_req(dmem_req), .dmem_we(dmem_we), .ir_we(ir_we),
    .pc_we(pc_we), .reg_write(reg_write), .mem_to_reg(mem_to_reg), .imm_src(imm_src),
    .alu_src(alu_src), .wd_src(wd_src), .pc_src(pc_src), .halt(halt), .err(err),
    .state(state)
  );

  always #5 clk = ~clk;

  logic [18:0] dut_vec;
  assign dut_vec = {state, imem_req, dmem_req, dmem_we, ir_we, pc_we, reg_write,
                    mem_to_reg, imm_src, alu_src, wd_src, pc_src, halt, err};

  int checks = 0;
  int passed = 0;
  logic [18:0] exp_q[$];

  typedef struct packed {
    logic       legal;
    logic       brk;
    logic       mem;
    logic       st;
    logic       ld;
    logic [1:0] imm;
    logic       alu;
    logic [1:0] wd;
    logic [1:0] pc;
  } ref_t;

  task automatic check(input string tag, input logic [18:0] got, input logic [18:0] exp);
    checks++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %b expected %b at t=%0t", tag, got, exp, $time);
  endtask

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  // Opcode table: what each instruction class drives in EXEC/MEM/WB.
  function automatic ref_t ref_of(input logic [6:0] o);
    ref_t r;
    r = '0;
    r.legal = 1'b1;
    case (o)
      7'b0110111: begin r.imm = 2'b01; r.wd = 2'b10; end
      7'b0010111: begin r.imm = 2'b01; r.wd = 2'b11; end
      7'b1101111: begin r.imm = 2'b10; r.wd = 2'b01; r.pc = 2'b01; end
      7'b1100111: begin r.alu = 1'b1; r.wd = 2'b01; r.pc = 2'b10; end
      7'b0010011: r.alu = 1'b1;
      7'b0110011: ;
      7'b0000011: begin r.alu = 1'b1; r.mem = 1'b1; r.ld = 1'b1; end
      7'b0100011: begin r.alu = 1'b1; r.mem = 1'b1; r.st = 1'b1; r.imm = 2'b11; end
      7'b1110011: r.brk = 1'b1;
      default:    r.legal = 1'b0;
    endcase
    return r;
  endfunction

  // Expected output vector for a phase (0..6) of an instruction described by r.
  function automatic logic [18:0] vec(input int ph, input ref_t r, input logic e);
    logic       ireq, dreq, dwe, irw, pcw, rw, m2r, alu, h, er;
    logic [1:0] imm, wd, pc;
    {ireq, dreq, dwe, irw, pcw, rw, m2r, alu, h, er} = '0;
    {imm, wd, pc} = '0;
    if (ph == 1) begin ireq = 1'b1; irw = 1'b1; end
    if (ph >= 3 && ph <= 5) begin imm = r.imm; alu = r.alu; end
    if (ph == 4) begin dreq = 1'b1; dwe = r.st; end
    if (ph == 5) begin
      pcw = 1'b1; rw = ~r.st; m2r = r.ld; wd = r.wd; pc = r.pc;
    end
    if (ph == 6) begin h = 1'b1; er = e; end
    return {3'(ph), ireq, dreq, dwe, irw, pcw, rw, m2r, imm, alu, wd, pc, h, er};
  endfunction

  // Check the current cycle at the falling edge, then drive this cycle's acks.
  task automatic step(input string tag, input logic [18:0] v, input logic ia, input logic da);
    exp_q.push_back(v);
    @(negedge clk);
    check(tag, dut_vec, exp_q.pop_front());
    imem_ack = ia;
    dmem_ack = da;
  endtask

  task automatic release_reset();
    @(posedge clk);
    #1 rst = 1'b0;
    step("idle", '0, rb(), rb());
  endtask

  task automatic do_reset();
    rst = 1'b1;
    imem_ack = 1'b0;
    dmem_ack = 1'b0;
    @(posedge clk);
    #1 check("reset", dut_vec, '0);
    release_reset();
  endtask

  task automatic halt_run(input logic e);
    for (int i = 0; i < 20; i++) step("halt", vec(6, '0, e), rb(), rb());
    do_reset();
  endtask

  // One instruction: iw/dw are no-ack cycles before the ack (> MW means timeout),
  // rst_at >= 0 asserts reset asynchronously during that MEM cycle.
  task automatic run_instr(input logic [6:0] o, input int iw, input int dw, input int rst_at);
    ref_t r;
    r = ref_of(o);
    op = o;
    for (int k = 0; k <= MW; k++) begin
      if (k == iw) begin
        step("fetch", vec(1, r, 1'b0), 1'b1, rb());
        break;
      end
      step("fetch", vec(1, r, 1'b0), 1'b0, rb());
      if (k == MW) begin
        halt_run(1'b1);
        return;
      end
    end
    step("decode", vec(2, r, 1'b0), rb(), rb());
    if (!r.legal || r.brk) begin
      halt_run(!r.legal);
      return;
    end
    step("exec", vec(3, r, 1'b0), rb(), rb());
    if (r.mem) begin
      for (int k = 0; k <= MW; k++) begin
        if (k == rst_at) begin
          step("mem", vec(4, r, 1'b0), 1'b0, 1'b1);
          #2 rst = 1'b1;
          #1 check("async_rst", dut_vec, '0);
          imem_ack = 1'b0;
          dmem_ack = 1'b0;
          release_reset();
          return;
        end
        if (k == dw) begin
          step("mem", vec(4, r, 1'b0), rb(), 1'b1);
          break;
        end
        step("mem", vec(4, r, 1'b0), rb(), 1'b0);
        if (k == MW) begin
          halt_run(1'b1);
          return;
        end
      end
    end
    step("wb", vec(5, r, 1'b0), rb(), rb());
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [6:0] ops[9];
    logic [6:0] o;
    int iw, dw, ra;
    ops = '{7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111, 7'b0010011,
            7'b0110011, 7'b0000011, 7'b0100011, 7'b1110011};
    do_reset();
    run_instr(7'b0010011, 0, 0, -1);   // addi
    run_instr(7'b1101111, 0, 0, -1);   // jal
    run_instr(7'b1100111, 1, 0, -1);   // jalr
    run_instr(7'b0000011, 0, 3, -1);   // load, ack in the expiry cycle
    run_instr(7'b0100011, 2, 0, -1);   // store
    run_instr(7'b0110111, 0, 0, -1);   // lui
    run_instr(7'b0010111, 0, 0, -1);   // auipc
    run_instr(7'b0110011, MW, 0, -1);  // op, fetch ack in the expiry cycle
    run_instr(7'b0000011, 0, 2, 1);    // reset mid-MEM
    run_instr(7'b1110011, 0, 0, -1);   // ebreak
    run_instr(7'b1111111, 0, 0, -1);   // illegal
    run_instr(7'b0010011, MW + 1, 0, -1); // fetch timeout
    run_instr(7'b0100011, 0, MW + 1, -1); // store timeout
    for (int n = 0; n < 200; n++) begin
      if ($urandom_range(0, 11) < 9) o = ops[$urandom_range(0, 8)];
      else o = 7'($urandom_range(0, 127));
      iw = ($urandom_range(0, 9) == 0) ? MW + 1 : $urandom_range(0, MW);
      dw = ($urandom_range(0, 9) == 0) ? MW + 1 : $urandom_range(0, MW);
      ra = ($urandom_range(0, 24) == 0) ? $urandom_range(0, MW) : -1;
      run_instr(o, iw, dw, ra);
    end
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
